tx_framer: RTL

//  Frames the packed edge-map byte stream from the packer before the UART TX head.

---
 rtl/tx_framer_pkg.sv | 15 +
 rtl/tx_framer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/tx_framer_pkg.sv
// Shared types and default sync bytes for the TX framer; the host-side decoder uses the same constants.
package tx_framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        PAY,
        CSUM
    } state_e;

    localparam logic [7:0] SYNC0_DEF = 8'hA5;
    localparam logic [7:0] SYNC1_DEF = 8'h5A;

endpackage

// File: rtl/tx_framer.sv
// Frames the packed edge-map byte stream: 2-byte sync header, BYTES_LP payload bytes, optional XOR trailer.
// Trailer enabled by defining TX_FRAMER_CHECKSUM_EN. Payload passes through with 0-cycle latency; header/trailer hold until ready_i.
module tx_framer
    import tx_framer_pkg::*;
#(
    parameter int                 width_p    = 8,
    parameter int                 image_w_p  = 320,
    parameter int                 image_h_p  = 240,
    parameter int                 pack_num_p = 8,
    parameter logic [width_p-1:0] sync0_p    = width_p'(SYNC0_DEF),
    parameter logic [width_p-1:0] sync1_p    = width_p'(SYNC1_DEF)
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [width_p-1:0] data_o,
    output logic               frame_done_o,
    output logic [15:0]        frame_cnt_o
);

    localparam int BYTES_LP = image_w_p * image_h_p / pack_num_p;
    localparam int CNT_W    = (BYTES_LP > 1) ? $clog2(BYTES_LP) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_LP - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        frame_cnt_q;
`ifdef TX_FRAMER_CHECKSUM_EN
    logic [width_p-1:0] csum_q;
`endif

    logic pay_hs;
    logic pay_last;
    assign pay_hs   = (state_q == PAY) && valid_i && ready_i;
    assign pay_last = pay_hs && (cnt_q == LAST_CNT);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
`ifdef TX_FRAMER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // The waiting input byte stays upstream until PAY.
                    if (valid_i) begin
                        state_q <= HDR0;
`ifdef TX_FRAMER_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                HDR0: if (ready_i) state_q <= HDR1;
                HDR1: if (ready_i) state_q <= PAY;
                PAY: begin
                    if (pay_hs) begin
`ifdef TX_FRAMER_CHECKSUM_EN
                        csum_q <= csum_q ^ data_i;
`endif
                        if (pay_last) begin
                            cnt_q <= '0;
`ifdef TX_FRAMER_CHECKSUM_EN
                            state_q <= CSUM;
`else
                            state_q     <= IDLE;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
`ifdef TX_FRAMER_CHECKSUM_EN
                CSUM: begin
                    if (ready_i) begin
                        state_q     <= IDLE;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        valid_o      = 1'b0;
        ready_o      = 1'b0;
        data_o       = '0;
        frame_done_o = 1'b0;
        case (state_q)
            HDR0: begin
                valid_o = 1'b1;
                data_o  = sync0_p;
            end
            HDR1: begin
                valid_o = 1'b1;
                data_o  = sync1_p;
            end
            PAY: begin
                valid_o = valid_i;
                ready_o = ready_i;
                data_o  = data_i;
`ifndef TX_FRAMER_CHECKSUM_EN
                frame_done_o = pay_last;
`endif
            end
`ifdef TX_FRAMER_CHECKSUM_EN
            CSUM: begin
                valid_o      = 1'b1;
                data_o       = csum_q;
                frame_done_o = ready_i;
            end
`endif
            default: ;
        endcase
    end

    assign frame_cnt_o = frame_cnt_q;

endmodule
